// File: rtl/text_command_decoder_pkg.sv
// Shared constants, state encoding and helpers for the text command decoder.
package text_command_decoder_pkg;

  localparam int DEFAULT_TEXT_COLS = 100;
  localparam int DEFAULT_TEXT_ROWS = 50;
  localparam int TEXTCOLS_W = 7;
  localparam int TEXTROWS_W = 6;

  localparam logic [7:0] OP_SET_CURSOR = 8'h01;
  localparam logic [7:0] OP_SET_ATTR   = 8'h02;
  localparam logic [7:0] OP_STREAM     = 8'h03;
  localparam logic [7:0] OP_FILL       = 8'h04;

  localparam logic [7:0] RESET_ATTR1 = 8'h07;
  localparam logic [7:0] RESET_ATTR2 = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARG_X   = 3'd1,
    ST_ARG_Y   = 3'd2,
    ST_ARG_A1  = 3'd3,
    ST_ARG_A2  = 3'd4,
    ST_STREAM  = 3'd5,
    ST_FILL_C  = 3'd6,
    ST_FILLING = 3'd7
  } state_t;

  function automatic logic arg_in_range(input logic [7:0] arg, input int limit);
    return (int'(arg) < limit);
  endfunction

endpackage

// File: rtl/text_command_decoder_cursor.sv
// Text cursor: holds (x, y) and implements row-major advance with full-screen wrap.
module text_cursor
  import text_command_decoder_pkg::*;
#(
  parameter int TEXT_COLS = DEFAULT_TEXT_COLS,
  parameter int TEXT_ROWS = DEFAULT_TEXT_ROWS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [TEXTCOLS_W-1:0] load_x,
  input  logic [TEXTROWS_W-1:0] load_y,
  input  logic                  advance,
  input  logic                  clear,
  output logic [TEXTCOLS_W-1:0] x,
  output logic [TEXTROWS_W-1:0] y,
  output logic [TEXTCOLS_W-1:0] adv_x,
  output logic [TEXTROWS_W-1:0] adv_y
);

  localparam logic [TEXTCOLS_W-1:0] X_LAST = TEXTCOLS_W'(TEXT_COLS - 1);
  localparam logic [TEXTROWS_W-1:0] Y_LAST = TEXTROWS_W'(TEXT_ROWS - 1);

  // Successor position of the current cursor.
  always_comb begin
    if (x == X_LAST) begin
      adv_x = '0;
      if (y == Y_LAST) begin
        adv_y = '0;
      end else begin
        adv_y = y + TEXTROWS_W'(1);
      end
    end else begin
      adv_x = x + TEXTCOLS_W'(1);
      adv_y = y;
    end
  end

  // Cursor storage; clear beats load beats advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= load_x;
      y <= load_y;
    end else if (advance) begin
      x <= adv_x;
      y <= adv_y;
    end else begin
      x <= x;
      y <= y;
    end
  end

endmodule

// File: rtl/text_command_decoder.sv
// Decodes received I2C bytes into text video-memory writes: cursor moves,
// attribute changes, character streams and whole-screen fills.
module text_command_decoder
  import text_command_decoder_pkg::*;
#(
  parameter int TEXT_COLS = DEFAULT_TEXT_COLS,
  parameter int TEXT_ROWS = DEFAULT_TEXT_ROWS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  write,
  output logic [TEXTCOLS_W-1:0] xtextwrite,
  output logic [TEXTROWS_W-1:0] ytextwrite,
  output logic [23:0]           value,
  output logic                  busy,
  output logic                  overrun,
  output logic                  cmd_error
);

  localparam logic [TEXTCOLS_W-1:0] X_LAST = TEXTCOLS_W'(TEXT_COLS - 1);
  localparam logic [TEXTROWS_W-1:0] Y_LAST = TEXTROWS_W'(TEXT_ROWS - 1);

  state_t                state_r, state_s;
  logic                  frame_s, fill_last_s;
  logic [TEXTCOLS_W-1:0] cur_x_s, adv_x_s, wx_s;
  logic [TEXTROWS_W-1:0] cur_y_s, adv_y_s, wy_s;
  logic                  cur_load_s, cur_adv_s, cur_clear_s;
  logic [7:0]            x_arg_r, x_arg_s, a1_arg_r, a1_arg_s;
  logic [7:0]            attr1_r, attr1_s, attr2_r, attr2_s;
  logic                  write_s, err_set_s, ovr_set_s;
  logic [23:0]           value_s;

  assign frame_s     = frame_start | frame_end;
  assign fill_last_s = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);

  text_cursor #(
    .TEXT_COLS (TEXT_COLS),
    .TEXT_ROWS (TEXT_ROWS)
  ) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .load    (cur_load_s),
    .load_x  (x_arg_r[TEXTCOLS_W-1:0]),
    .load_y  (byte_data[TEXTROWS_W-1:0]),
    .advance (cur_adv_s),
    .clear   (cur_clear_s),
    .x       (cur_x_s),
    .y       (cur_y_s),
    .adv_x   (adv_x_s),
    .adv_y   (adv_y_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; a running fill ignores frame boundaries until its last cell.
  always_comb begin
    state_s = state_r;
    if (state_r == ST_FILLING) begin
      if (fill_last_s) begin
        state_s = ST_IDLE;
      end else begin
        state_s = ST_FILLING;
      end
    end else if (frame_s) begin
      state_s = ST_IDLE;
    end else if (byte_valid) begin
      case (state_r)
        ST_IDLE: begin
          case (byte_data)
            OP_SET_CURSOR: state_s = ST_ARG_X;
            OP_SET_ATTR:   state_s = ST_ARG_A1;
            OP_STREAM:     state_s = ST_STREAM;
            OP_FILL:       state_s = ST_FILL_C;
            default:       state_s = ST_IDLE;
          endcase
        end
        ST_ARG_X:  state_s = ST_ARG_Y;
        ST_ARG_A1: state_s = ST_ARG_A2;
        ST_STREAM: state_s = ST_STREAM;
        ST_FILL_C: state_s = ST_FILLING;
        default:   state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Per-state actions. During a fill the cursor runs one cell behind the
  // write address, so the registered write carries the cursor's successor.
  always_comb begin
    write_s     = 1'b0;
    wx_s        = xtextwrite;
    wy_s        = ytextwrite;
    value_s     = value;
    cur_load_s  = 1'b0;
    cur_adv_s   = 1'b0;
    cur_clear_s = 1'b0;
    x_arg_s     = x_arg_r;
    a1_arg_s    = a1_arg_r;
    attr1_s     = attr1_r;
    attr2_s     = attr2_r;
    err_set_s   = 1'b0;
    ovr_set_s   = 1'b0;
    if (state_r == ST_FILLING) begin
      cur_adv_s = 1'b1;
      ovr_set_s = byte_valid;
      if (!fill_last_s) begin
        write_s = 1'b1;
        wx_s    = adv_x_s;
        wy_s    = adv_y_s;
      end else begin
        write_s = 1'b0;
      end
    end else if (byte_valid && !frame_s) begin
      case (state_r)
        ST_IDLE: begin
          case (byte_data)
            OP_SET_CURSOR, OP_SET_ATTR, OP_STREAM, OP_FILL: err_set_s = 1'b0;
            default: err_set_s = 1'b1;
          endcase
        end
        ST_ARG_X: x_arg_s = byte_data;
        ST_ARG_Y: begin
          if (arg_in_range(x_arg_r, TEXT_COLS) && arg_in_range(byte_data, TEXT_ROWS)) begin
            cur_load_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end
        ST_ARG_A1: a1_arg_s = byte_data;
        ST_ARG_A2: begin
          attr1_s = a1_arg_r;
          attr2_s = byte_data;
        end
        ST_STREAM: begin
          write_s   = 1'b1;
          wx_s      = cur_x_s;
          wy_s      = cur_y_s;
          value_s   = {attr2_r, attr1_r, byte_data};
          cur_adv_s = 1'b1;
        end
        ST_FILL_C: begin
          write_s     = 1'b1;
          wx_s        = '0;
          wy_s        = '0;
          value_s     = {attr2_r, attr1_r, byte_data};
          cur_clear_s = 1'b1;
        end
        default: err_set_s = 1'b0;
      endcase
    end else begin
      write_s = 1'b0;
    end
  end

  // Registered outputs, attributes, argument latches and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= 24'h000000;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      cmd_error  <= 1'b0;
      x_arg_r    <= 8'h00;
      a1_arg_r   <= 8'h00;
      attr1_r    <= RESET_ATTR1;
      attr2_r    <= RESET_ATTR2;
    end else begin
      write      <= write_s;
      xtextwrite <= wx_s;
      ytextwrite <= wy_s;
      value      <= value_s;
      busy       <= (state_s == ST_FILLING);
      overrun    <= overrun | ovr_set_s;
      cmd_error  <= cmd_error | err_set_s;
      x_arg_r    <= x_arg_s;
      a1_arg_r   <= a1_arg_s;
      attr1_r    <= attr1_s;
      attr2_r    <= attr2_s;
    end
  end

endmodule
